muldiv_unit: RTL and testbench

- Iterative MIPS multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file. Takes rs/rt operands from the regfile read ports (rdata1_out/rdata2_out) in the execute stage.
- Produces the HI/LO values that MFHI/MFLO return to the regfile write-back mux.
- Raises a stall to the pipeline control while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_iter.sv | 35 +++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes, FSM states,
// and the divide-by-zero quotient constant.
package muldiv_pkg;
   localparam int MULDIV_W = 32;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [MULDIV_W-1:0] DIV0_LO = '1;
endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between the pipeline (master) and the multiply/divide
// unit (slave): request, operands, HI/LO readout and stall/done status.
interface muldiv_if import muldiv_pkg::*; #(
   parameter int W = MULDIV_W
);
   logic         start;
   op_e          op;
   logic [W-1:0] rs_in;
   logic [W-1:0] rt_in;
   logic         mf_req;
   logic [W-1:0] hi_out;
   logic [W-1:0] lo_out;
   logic         busy;
   logic         stall_out;
   logic         done;

   modport master (
      output start, op, rs_in, rt_in, mf_req,
      input  hi_out, lo_out, busy, stall_out, done
   );

   modport slave (
      input  start, op, rs_in, rt_in, mf_req,
      output hi_out, lo_out, busy, stall_out, done
   );
endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the magnitude datapath: a shift-add multiply step or a
// restoring-division step, chosen by is_div.
module muldiv_iter #(
   parameter int W = 32
) (
   input  logic         is_div,
   input  logic [W-1:0] hi,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] m,
   output logic [W-1:0] hi_nxt,
   output logic [W-1:0] lo_nxt
);
   logic [W:0]   sum;
   logic [W:0]   shifted;
   logic [1:0]   borrow;
   logic [W-1:0] diff;

   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      shifted = {hi, lo[W-1]};
      // The partial remainder stays below m, so a non-negative difference
      // always fits in W bits; any borrow shows up as 2'b11.
      {borrow, diff} = {1'b0, shifted} - {2'b00, m};
      if (!is_div) begin
         hi_nxt = sum[W:1];
         lo_nxt = {sum[0], lo[W-1:1]};
      end else if (borrow == 2'b00) begin
         hi_nxt = diff;
         lo_nxt = {lo[W-2:0], 1'b1};
      end else begin
         hi_nxt = shifted[W-1:0];
         lo_nxt = {lo[W-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU; divide stays iterative.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int W = MULDIV_W
) (
   input logic     clock,
   input logic     reset,
   muldiv_if.slave bus
);
   localparam int ITER = W;
   localparam int CW   = $clog2(ITER + 1);

   state_e         state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   hi, lo, acc_hi, acc_lo, m;
   logic           is_div, neg_q, neg_r, div_zero, busy, done;
   logic [W-1:0]   step_hi, step_lo;
   logic           is_signed, rs_neg, rt_neg;
   logic [W-1:0]   rs_mag, rt_mag;
   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0]   q_fix, r_fix;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fast_mag, fast_prod;
`endif

   muldiv_iter #(.W(W)) u_iter (
      .is_div (is_div),
      .hi     (acc_hi),
      .lo     (acc_lo),
      .m      (m),
      .hi_nxt (step_hi),
      .lo_nxt (step_lo)
   );

   always_comb begin
      is_signed = (bus.op == MULT) || (bus.op == DIV);
      rs_neg    = is_signed & bus.rs_in[W-1];
      rt_neg    = is_signed & bus.rt_in[W-1];
      rs_mag    = rs_neg ? -bus.rs_in : bus.rs_in;
      rt_mag    = rt_neg ? -bus.rt_in : bus.rt_in;
      prod      = {step_hi, step_lo};
      prod_fix  = neg_q ? -prod : prod;
      // Remainder sign-fix of the dividend magnitude restores rs_in for /0.
      q_fix     = div_zero ? W'(DIV0_LO) : (neg_q ? -step_lo : step_lo);
      r_fix     = neg_r ? -step_hi : step_hi;
`ifdef MULDIV_FAST_MUL_EN
      fast_mag  = {{W{1'b0}}, rs_mag} * {{W{1'b0}}, rt_mag};
      fast_prod = (rs_neg ^ rt_neg) ? -fast_mag : fast_mag;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         m        <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     MULT, MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                        {hi, lo} <= fast_prod;
                        done     <= 1'b1;
`else
                        acc_hi   <= '0;
                        acc_lo   <= rt_mag;
                        m        <= rs_mag;
                        is_div   <= 1'b0;
                        neg_q    <= rs_neg ^ rt_neg;
                        neg_r    <= 1'b0;
                        div_zero <= 1'b0;
                        cnt      <= CW'(ITER);
                        busy     <= 1'b1;
                        state    <= RUN;
`endif
                     end
                     DIV, DIVU: begin
                        acc_hi   <= '0;
                        acc_lo   <= rs_mag;
                        m        <= rt_mag;
                        is_div   <= 1'b1;
                        neg_q    <= rs_neg ^ rt_neg;
                        neg_r    <= rs_neg;
                        div_zero <= (bus.rt_in == '0);
                        cnt      <= CW'(ITER);
                        busy     <= 1'b1;
                        state    <= RUN;
                     end
                     MTHI:    hi <= bus.rs_in;
                     MTLO:    lo <= bus.rs_in;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (is_div) begin
                     hi <= r_fix;
                     lo <= q_fix;
                  end else begin
                     {hi, lo} <= prod_fix;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.hi_out    = hi;
   assign bus.lo_out    = lo;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.stall_out = busy & (bus.start | bus.mf_req);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: MTHI/MTLO, signed/unsigned mul/div,
// divide corner cases, stall/held-start handshake and mid-operation reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   muldiv_if #(.W(32)) bus ();

   muldiv_unit #(.W(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_iter(input string tag, input op_e o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int unsigned cycles;
      int unsigned early_done;
      bus.start = 1'b1; bus.op = o; bus.rs_in = a; bus.rt_in = b;
      tick();
      bus.start = 1'b0;
      cycles = 0;
      early_done = 0;
      while (bus.busy && cycles < 100) begin
         cycles++;
         if (bus.done) early_done++;
         tick();
      end
      check({tag, "_cycles"}, cycles, 32);
      check({tag, "_early_done"}, early_done, 0);
      check({tag, "_done"}, {31'd0, bus.done}, 1);
      check({tag, "_hi"}, bus.hi_out, eh);
      check({tag, "_lo"}, bus.lo_out, el);
      tick();
      check({tag, "_done_clr"}, {31'd0, bus.done}, 0);
   endtask

`ifdef MULDIV_FAST_MUL_EN
   task automatic run_fast(input string tag, input op_e o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      bus.start = 1'b1; bus.op = o; bus.rs_in = a; bus.rt_in = b;
      tick();
      bus.start = 1'b0;
      check({tag, "_busy"}, {31'd0, bus.busy}, 0);
      check({tag, "_done"}, {31'd0, bus.done}, 1);
      check({tag, "_hi"}, bus.hi_out, eh);
      check({tag, "_lo"}, bus.lo_out, el);
      tick();
      check({tag, "_done_clr"}, {31'd0, bus.done}, 0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned stall_bad;
      int unsigned lo_bad;
      int unsigned cycles;
      op_e abort_op;

      bus.start = 1'b0; bus.op = MULT; bus.rs_in = '0; bus.rt_in = '0; bus.mf_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_hi", bus.hi_out, 0);
      check("rst_lo", bus.lo_out, 0);
      check("rst_busy", {31'd0, bus.busy}, 0);
      check("rst_done", {31'd0, bus.done}, 0);
      check("rst_stall", {31'd0, bus.stall_out}, 0);

      // start and mf_req together in IDLE: old HI visible, no stall
      bus.start = 1'b1; bus.op = MTHI; bus.rs_in = 32'h1234_5678; bus.mf_req = 1'b1;
      #1;
      check("mf_idle_stall", {31'd0, bus.stall_out}, 0);
      check("mf_idle_hi_old", bus.hi_out, 0);
      tick();
      bus.mf_req = 1'b0; bus.op = MTLO; bus.rs_in = 32'h9ABC_DEF0;
      tick();
      bus.start = 1'b0;
      check("mt_hi", bus.hi_out, 32'h1234_5678);
      check("mt_lo", bus.lo_out, 32'h9ABC_DEF0);
      check("mt_busy", {31'd0, bus.busy}, 0);
      check("mt_done", {31'd0, bus.done}, 0);

`ifdef MULDIV_FAST_MUL_EN
      run_fast("mult_neg", MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_fast("multu", MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
      run_fast("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      abort_op = DIVU;
`else
      run_iter("mult_neg", MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_iter("multu", MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
      run_iter("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      abort_op = MULT;
`endif
      run_iter("div_neg", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_iter("divu_zero", DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
      run_iter("div_zero_neg", DIV, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      run_iter("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

      // mf_req during an in-flight divide stalls every busy cycle
      bus.start = 1'b1; bus.op = DIV; bus.rs_in = 32'd100; bus.rt_in = 32'd7;
      tick();
      bus.start = 1'b0; bus.mf_req = 1'b1;
      stall_bad = 0; cycles = 0;
      while (bus.busy && cycles < 100) begin
         cycles++;
         if (!bus.stall_out) stall_bad++;
         tick();
      end
      check("mf_stall_cycles", cycles, 32);
      check("mf_stall_miss", stall_bad, 0);
      check("mf_stall_release", {31'd0, bus.stall_out}, 0);
      check("mf_div_hi", bus.hi_out, 32'd2);
      check("mf_div_lo", bus.lo_out, 32'd14);
      bus.mf_req = 1'b0;
      tick();

      // held MTLO is ignored while busy and taken once busy drops
      bus.start = 1'b1; bus.op = DIV; bus.rs_in = 32'd100; bus.rt_in = 32'd7;
      tick();
      bus.op = MTLO; bus.rs_in = 32'hCAFE_F00D;
      stall_bad = 0; lo_bad = 0; cycles = 0;
      while (bus.busy && cycles < 100) begin
         cycles++;
         if (!bus.stall_out) stall_bad++;
         if (bus.lo_out !== 32'd14) lo_bad++;
         tick();
      end
      check("held_cycles", cycles, 32);
      check("held_stall_miss", stall_bad, 0);
      check("held_lo_ignored", lo_bad, 0);
      check("held_div_lo", bus.lo_out, 32'd14);
      tick();
      bus.start = 1'b0;
      check("held_mtlo_lo", bus.lo_out, 32'hCAFE_F00D);
      check("held_mtlo_hi", bus.hi_out, 32'd2);
      check("held_mtlo_busy", {31'd0, bus.busy}, 0);

      // reset at iteration 10 aborts and zeroes HI/LO
      bus.start = 1'b1; bus.op = abort_op; bus.rs_in = 32'd5; bus.rt_in = 32'd7;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("abort_busy_pre", {31'd0, bus.busy}, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'd0, bus.busy}, 0);
      check("abort_hi", bus.hi_out, 0);
      check("abort_lo", bus.lo_out, 0);
      check("abort_done", {31'd0, bus.done}, 0);
      tick();
      check("abort_done_idle", {31'd0, bus.done}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
